// File: rtl/dcache_responder_pkg.sv
// Shared definitions for the direct-mapped, write-through data cache responder:
// FSM states, memory request types and bus widths.
package dcache_responder_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BYTES  = DATA_W / 8;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

  localparam logic [BYTES-1:0] MASK_ALL = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } state_e;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// CPU-side and memory-side signals of the data cache responder.
// slave = the cache itself, master = CPU plus memory environment.
interface dcache_responder_if;
  import dcache_responder_pkg::*;

  logic [ADDR_W-1:0] dcache_addr;
  logic              dcache_re;
  logic [BYTES-1:0]  dcache_we;
  logic [DATA_W-1:0] dcache_din;
  logic [DATA_W-1:0] dcache_dout;
  logic              stall;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic [BYTES-1:0]  mem_req_mask;

  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  modport slave (
    input  dcache_addr, dcache_re, dcache_we, dcache_din,
    output dcache_dout, stall,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
    input  mem_req_ready,
    input  mem_resp_valid, mem_resp_data
  );

  modport master (
    output dcache_addr, dcache_re, dcache_we, dcache_din,
    input  dcache_dout, stall,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
    output mem_req_ready,
    output mem_resp_valid, mem_resp_data
  );

endinterface

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the cache: one combinational read port and one
// byte-masked write port. Only the valid bits are reset.
module dcache_array
  import dcache_responder_pkg::*;
#(
  parameter int LINES = 64,
  parameter int TAG_W = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(LINES)-1:0] rd_index,
  output logic                     rd_valid,
  output logic [TAG_W-1:0]         rd_tag,
  output logic [DATA_W-1:0]        rd_data,
  input  logic                     wr_en,
  input  logic [$clog2(LINES)-1:0] wr_index,
  input  logic [TAG_W-1:0]         wr_tag,
  input  logic [BYTES-1:0]         wr_mask,
  input  logic [DATA_W-1:0]        wr_data
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] valid_d;
  logic [TAG_W-1:0] tag_mem [LINES];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[wr_index] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index] <= wr_tag;
    end
  end

  // Each byte lane is its own array so a partial write touches only its lanes.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      logic [7:0] lane_mem [LINES];

      always_ff @(posedge clk) begin
        if (wr_en && wr_mask[gi]) begin
          lane_mem[wr_index] <= wr_data[8*gi +: 8];
        end
      end

      assign rd_data[8*gi +: 8] = lane_mem[rd_index];
    end
  endgenerate

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped one-word-line data cache: single-cycle read hits, blocking read
// misses, write-through / no-write-allocate stores over a valid/ready channel.
module dcache_responder
  import dcache_responder_pkg::*;
#(
  parameter int LINES         = 64,
  parameter int MEM_ADDR_BITS = 32
) (
  input  logic              clk,
  input  logic              reset,
  dcache_responder_if.slave bus
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = MEM_ADDR_BITS - IDX_W - 2;

  state_e            state_q, state_d;
  logic              stall_q, stall_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              req_valid_q, req_valid_d;
  logic              req_rw_q, req_rw_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic [BYTES-1:0]  req_mask_q, req_mask_d;

  logic [IDX_W-1:0]  cpu_index;
  logic [TAG_W-1:0]  cpu_tag;
  logic              arr_rd_valid;
  logic [TAG_W-1:0]  arr_rd_tag;
  logic [DATA_W-1:0] arr_rd_data;
  logic              hit;

  logic              arr_wr_en;
  logic [IDX_W-1:0]  arr_wr_index;
  logic [TAG_W-1:0]  arr_wr_tag;
  logic [BYTES-1:0]  arr_wr_mask;
  logic [DATA_W-1:0] arr_wr_data;

  assign cpu_index = bus.dcache_addr[IDX_W+1:2];
  assign cpu_tag   = bus.dcache_addr[MEM_ADDR_BITS-1:IDX_W+2];
  assign hit       = arr_rd_valid && (arr_rd_tag == cpu_tag);

  dcache_array #(
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_index (cpu_index),
    .rd_valid (arr_rd_valid),
    .rd_tag   (arr_rd_tag),
    .rd_data  (arr_rd_data),
    .wr_en    (arr_wr_en),
    .wr_index (arr_wr_index),
    .wr_tag   (arr_wr_tag),
    .wr_mask  (arr_wr_mask),
    .wr_data  (arr_wr_data)
  );

  always_comb begin
    state_d      = state_q;
    dout_d       = dout_q;
    req_valid_d  = req_valid_q;
    req_rw_d     = req_rw_q;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
    req_mask_d   = req_mask_q;
    arr_wr_en    = 1'b0;
    arr_wr_index = cpu_index;
    arr_wr_tag   = cpu_tag;
    arr_wr_mask  = bus.dcache_we;
    arr_wr_data  = bus.dcache_din;

    case (state_q)
      IDLE: begin
        // A store takes priority over a simultaneous load.
        if (bus.dcache_we != '0) begin
          arr_wr_en   = hit;
          state_d     = WR_REQ;
          req_valid_d = 1'b1;
          req_rw_d    = MEM_WR;
          req_addr_d  = word_align(bus.dcache_addr);
          req_data_d  = bus.dcache_din;
          req_mask_d  = bus.dcache_we;
        end else if (bus.dcache_re) begin
          if (hit) begin
            dout_d = arr_rd_data;
          end else begin
            state_d     = RD_REQ;
            req_valid_d = 1'b1;
            req_rw_d    = MEM_RD;
            req_addr_d  = word_align(bus.dcache_addr);
            req_data_d  = '0;
            req_mask_d  = MASK_ALL;
          end
        end
      end
      RD_REQ: begin
        if (bus.mem_req_ready) begin
          state_d     = RD_WAIT;
          req_valid_d = 1'b0;
        end
      end
      RD_WAIT: begin
        // The fill address comes from the held request, not the CPU bus.
        if (bus.mem_resp_valid) begin
          arr_wr_en    = 1'b1;
          arr_wr_index = req_addr_q[IDX_W+1:2];
          arr_wr_tag   = req_addr_q[MEM_ADDR_BITS-1:IDX_W+2];
          arr_wr_mask  = MASK_ALL;
          arr_wr_data  = bus.mem_resp_data;
          dout_d       = bus.mem_resp_data;
          state_d      = IDLE;
        end
      end
      WR_REQ: begin
        if (bus.mem_req_ready) begin
          state_d     = IDLE;
          req_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        req_valid_d = 1'b0;
      end
    endcase

    stall_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      stall_q     <= 1'b0;
      dout_q      <= '0;
      req_valid_q <= 1'b0;
      req_rw_q    <= MEM_RD;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      stall_q     <= stall_d;
      dout_q      <= dout_d;
      req_valid_q <= req_valid_d;
      req_rw_q    <= req_rw_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_mask_q  <= req_mask_d;
    end
  end

  assign bus.stall         = stall_q;
  assign bus.dcache_dout   = dout_q;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_rw    = req_rw_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_data  = req_data_q;
  assign bus.mem_req_mask  = req_mask_q;

endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: memory-coherence reference model (reads return
// memory contents; hit/miss predicted from which word each line holds).
module tb_dcache_responder;
  import dcache_responder_pkg::*;

  localparam int LINES = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dcache_responder_if bus();

  dcache_responder #(
    .LINES         (LINES),
    .MEM_ADDR_BITS (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: backing memory by word address, plus which word each line holds.
  logic [31:0] mem [int unsigned];
  bit          line_valid [LINES];
  int unsigned line_word  [LINES];
  logic [31:0] exp_dout;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int unsigned line_of(input logic [31:0] addr);
    return (addr >> 2) % LINES;
  endfunction

  function automatic bit model_hit(input logic [31:0] addr);
    return line_valid[line_of(addr)] && (line_word[line_of(addr)] == (addr >> 2));
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (!mem.exists(addr >> 2)) mem[addr >> 2] = $urandom;
    return mem[addr >> 2];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < LINES; i++) line_valid[i] = 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Continuous compare: dout against model, request stability under backpressure.
  logic rdy_edge;
  always @(posedge clk) rdy_edge = bus.mem_req_ready;

  initial begin : cmp
    bit          have = 1'b0;
    logic        pv, prw;
    logic [31:0] pa, pd;
    logic [3:0]  pm;
    forever begin
      @(negedge clk);
      if (reset) begin
        have = 1'b0;
      end else begin
        check32("dout", bus.dcache_dout, exp_dout);
        if (bus.mem_req_valid) check32("valid_implies_stall", {31'b0, bus.stall}, 32'd1);
        if (have && pv && !rdy_edge) begin
          check32("hold_valid", {31'b0, bus.mem_req_valid}, 32'd1);
          check32("hold_rw", {31'b0, bus.mem_req_rw}, {31'b0, prw});
          check32("hold_addr", bus.mem_req_addr, pa);
          check32("hold_data", bus.mem_req_data, pd);
          check32("hold_mask", {28'b0, bus.mem_req_mask}, {28'b0, pm});
        end
        have = 1'b1;
        pv   = bus.mem_req_valid;
        prw  = bus.mem_req_rw;
        pa   = bus.mem_req_addr;
        pd   = bus.mem_req_data;
        pm   = bus.mem_req_mask;
      end
    end
  end

  task automatic do_read(input logic [31:0] addr, input int rdy_gap, input int resp_gap,
                         output bit was_miss, output int stall_cycles);
    bit hit;
    logic [31:0] val;
    hit = model_hit(addr);
    bus.dcache_addr = addr;
    bus.dcache_re   = 1'b1;
    bus.dcache_we   = 4'h0;
    bus.dcache_din  = $urandom;
    tick();
    was_miss = !hit;
    stall_cycles = 0;
    if (hit) begin
      val = mem_word(addr);
      exp_dout = val;
      check32("rd_hit_stall", {31'b0, bus.stall}, 32'd0);
      check32("rd_hit_noreq", {31'b0, bus.mem_req_valid}, 32'd0);
      check32("rd_hit_dout", bus.dcache_dout, val);
      bus.dcache_re = 1'b0;
    end else begin
      stall_cycles = int'(bus.stall);
      check32("rd_miss_stall", {31'b0, bus.stall}, 32'd1);
      check32("rd_miss_valid", {31'b0, bus.mem_req_valid}, 32'd1);
      check32("rd_miss_rw", {31'b0, bus.mem_req_rw}, {31'b0, MEM_RD});
      check32("rd_miss_addr", bus.mem_req_addr, addr & ~32'h3);
      check32("rd_miss_mask", {28'b0, bus.mem_req_mask}, 32'hF);
      for (int i = 0; i < rdy_gap; i++) begin
        bus.mem_resp_valid = 1'($urandom % 2);
        bus.mem_resp_data  = $urandom;
        tick();
        bus.mem_resp_valid = 1'b0;
        stall_cycles += int'(bus.stall);
      end
      bus.mem_req_ready = 1'b1;
      tick();
      bus.mem_req_ready = 1'b0;
      stall_cycles += int'(bus.stall);
      check32("rd_wait_noreq", {31'b0, bus.mem_req_valid}, 32'd0);
      for (int i = 0; i < resp_gap; i++) begin
        tick();
        stall_cycles += int'(bus.stall);
      end
      val = mem_word(addr);
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = val;
      tick();
      bus.mem_resp_valid = 1'b0;
      bus.dcache_re      = 1'b0;
      exp_dout = val;
      line_valid[line_of(addr)] = 1'b1;
      line_word[line_of(addr)]  = addr >> 2;
      check32("fill_stall", {31'b0, bus.stall}, 32'd0);
      check32("fill_dout", bus.dcache_dout, val);
    end
    $display("READ  addr=%h %s data=%h stall_cycles=%0d", addr, hit ? "hit " : "miss", val, stall_cycles);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] din,
                          input bit re_too, input int rdy_gap, output int stall_cycles);
    logic [31:0] old, nw;
    bus.dcache_addr = addr;
    bus.dcache_re   = re_too;
    bus.dcache_we   = we;
    bus.dcache_din  = din;
    tick();
    stall_cycles = int'(bus.stall);
    check32("wr_stall", {31'b0, bus.stall}, 32'd1);
    check32("wr_valid", {31'b0, bus.mem_req_valid}, 32'd1);
    check32("wr_rw", {31'b0, bus.mem_req_rw}, {31'b0, MEM_WR});
    check32("wr_addr", bus.mem_req_addr, addr & ~32'h3);
    check32("wr_data", bus.mem_req_data, din);
    check32("wr_mask", {28'b0, bus.mem_req_mask}, {28'b0, we});
    old = mem_word(addr);
    nw  = old;
    for (int b = 0; b < 4; b++) if (we[b]) nw[8*b +: 8] = din[8*b +: 8];
    mem[addr >> 2] = nw;
    for (int i = 0; i < rdy_gap; i++) begin
      bus.mem_resp_valid = 1'($urandom % 2);
      bus.mem_resp_data  = $urandom;
      tick();
      bus.mem_resp_valid = 1'b0;
      stall_cycles += int'(bus.stall);
    end
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    bus.dcache_we     = 4'h0;
    bus.dcache_re     = 1'b0;
    check32("wr_done_stall", {31'b0, bus.stall}, 32'd0);
    check32("wr_done_valid", {31'b0, bus.mem_req_valid}, 32'd0);
    $display("WRITE addr=%h we=%b din=%h mem=%h stall_cycles=%0d", addr, we, din, nw, stall_cycles);
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_stall"}, {31'b0, bus.stall}, 32'd0);
    check32({tag, "_valid"}, {31'b0, bus.mem_req_valid}, 32'd0);
    check32({tag, "_dout"}, bus.dcache_dout, 32'd0);
    check32({tag, "_rw"}, {31'b0, bus.mem_req_rw}, 32'd0);
    check32({tag, "_addr"}, bus.mem_req_addr, 32'd0);
    check32({tag, "_data"}, bus.mem_req_data, 32'd0);
    check32({tag, "_mask"}, {28'b0, bus.mem_req_mask}, 32'd0);
  endtask

  // Reset in the middle of the current transaction, then a stray response.
  task automatic reset_mid(input string tag);
    #2;
    reset = 1'b1;
    exp_dout = 32'd0;
    model_clear();
    #1;
    check_reset_outputs(tag);
    bus.dcache_re = 1'b0;
    bus.dcache_we = 4'h0;
    bus.mem_req_ready = 1'b0;
    tick();
    reset = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hBAD0BAD0;
    tick();
    bus.mem_resp_valid = 1'b0;
    check32({tag, "_stray_stall"}, {31'b0, bus.stall}, 32'd0);
    check32({tag, "_stray_dout"}, bus.dcache_dout, 32'd0);
    $display("RESET %s", tag);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] bases [3];
    bases[0] = 32'h1000_0000;
    bases[1] = 32'h2000_0000;
    bases[2] = 32'h1000_0100;
    return bases[$urandom_range(2)] + ($urandom_range(3) << 2) + $urandom_range(3);
  endfunction

  initial begin
    bit miss;
    int sc;
    logic [31:0] a;

    reset = 1'b1;
    exp_dout = 32'd0;
    model_clear();
    bus.dcache_addr = '0; bus.dcache_re = 1'b0; bus.dcache_we = '0; bus.dcache_din = '0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
    tick();
    tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Cold read miss: ready immediately, response three cycles after the request.
    mem[32'h1000_0004 >> 2] = 32'hDEADBEEF;
    do_read(32'h1000_0004, 0, 2, miss, sc);
    check_int("cold_miss", int'(miss), 1);
    check_int("cold_stall_cycles", sc, 4);
    check32("cold_dout", bus.dcache_dout, 32'hDEADBEEF);

    do_read(32'h1000_0004, 0, 0, miss, sc);
    check_int("warm_hit", int'(miss), 0);
    check32("warm_dout", bus.dcache_dout, 32'hDEADBEEF);

    do_write(32'h1000_0004, 4'b0010, 32'h0000_AB00, 1'b0, 0, sc);
    do_read(32'h1000_0004, 0, 0, miss, sc);
    check_int("byte_wr_hit", int'(miss), 0);
    check32("byte_wr_dout", bus.dcache_dout, 32'hDEADABEF);

    // Write miss with backpressure; write wins over a simultaneous read.
    do_write(32'h2000_0000, 4'hF, 32'h1234_5678, 1'b1, 5, sc);
    check_int("wr_miss_stall_cycles", sc, 6);
    do_read(32'h2000_0000, 1, 1, miss, sc);
    check_int("wr_miss_no_alloc", int'(miss), 1);
    check32("wr_miss_mem_dout", bus.dcache_dout, 32'h1234_5678);

    do_read(32'h1000_0104, 0, 0, miss, sc);
    check_int("conflict_miss", int'(miss), 1);
    do_read(32'h1000_0004, 0, 0, miss, sc);
    check_int("conflict_evicted", int'(miss), 1);
    check32("conflict_dout", bus.dcache_dout, 32'hDEADABEF);

    // Reset while waiting for read data.
    bus.dcache_addr = 32'h1000_0008; bus.dcache_re = 1'b1;
    tick();
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    reset_mid("rst_rdwait");
    do_read(32'h1000_0004, 0, 0, miss, sc);
    check_int("after_reset_miss", int'(miss), 1);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(3) == 0) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = $urandom;
        tick();
        bus.mem_resp_valid = 1'b0;
      end
      a = rand_addr();
      if ($urandom_range(2) == 0)
        do_write(a, 4'($urandom_range(15, 1)), $urandom, 1'($urandom % 2), $urandom_range(3), sc);
      else
        do_read(a, $urandom_range(3), $urandom_range(3), miss, sc);
    end

    // Reset while a write waits for ready.
    bus.dcache_addr = 32'h1000_0004; bus.dcache_we = 4'hF; bus.dcache_din = 32'h5555_AAAA;
    tick();
    reset_mid("rst_wrreq");
    for (int n = 0; n < 20; n++) do_read(rand_addr(), $urandom_range(2), $urandom_range(2), miss, sc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_responder.md
DCACHE_RESPONDER -- requirements
Module: dcache_responder

Interface
REQ-001 The block SHALL have parameter LINES, default 64, giving the number of direct-mapped one-word lines (power of two).
REQ-002 The block SHALL have parameter `MEM_ADDR_BITS`, default 32, giving the byte-address width.
REQ-003 Port clk  input  1 SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1 SHALL be asynchronous and active-high.
REQ-005 Port dcache_addr  input  32: CPU byte address.
REQ-006 Port dcache_re  input  1: CPU read request.
REQ-007 Port dcache_we  input  4: CPU per-byte write enables.
REQ-008 Port dcache_din  input  32: CPU write data, already lane-aligned.
REQ-009 Port dcache_dout  output  32: read data to CPU.
REQ-010 Port stall  output  1: pipeline stall to CPU.
REQ-011 Ports mem_req_valid out 1, mem_req_ready in 1, mem_req_rw out 1 (1=write), mem_req_addr out 32, mem_req_data out 32, mem_req_mask out 4: memory request channel.
REQ-012 Ports mem_resp_valid in 1, mem_resp_data in 32: memory read response, no backpressure.

Function
REQ-013 States SHALL be IDLE, RD_REQ, RD_WAIT, WR_REQ; stall SHALL equal (state != IDLE).
REQ-014 In IDLE, a request is accepted on a rising edge when dcache_we != 0 or dcache_re = 1; with both asserted, the write wins and re is ignored.
REQ-015 Address decomposition: word offset [1:0] ignored; index = addr[log2(LINES)+1:2]; tag = remaining upper bits.
REQ-016 Read hit, accepted at edge N: dcache_dout SHALL hold line data from edge N; stall SHALL stay 0; latency one cycle.
REQ-017 Read miss: go to RD_REQ; assert mem_req_valid, rw=0, addr word-aligned (addr[1:0]=0), mask=4'hF.
REQ-018 RD_REQ: on the edge where mem_req_valid and mem_req_ready are both high, go to RD_WAIT.
REQ-019 RD_WAIT: on the edge where mem_resp_valid is high, the block SHALL fill the line (valid=1, tag, data), load dcache_dout with mem_resp_data, and go to IDLE.
REQ-020 mem_resp_valid outside RD_WAIT SHALL be ignored.
REQ-021 Writes SHALL be write-through and no-write-allocate.
REQ-022 On a write hit, only the bytes with dcache_we set are updated in the line at the acceptance edge.
REQ-023 On a write miss, the cache array SHALL be unchanged.
REQ-024 Every accepted write goes to WR_REQ with mem_req_valid=1, rw=1, word-aligned address, data=dcache_din, mask=dcache_we, all registered at acceptance.
REQ-025 WR_REQ: on the edge where mem_req_ready is high, go to IDLE.
REQ-026 mem_req_* outputs SHALL remain stable while mem_req_valid=1 and ready=0.
REQ-027 mem_req_valid SHALL be 0 in IDLE and RD_WAIT.
REQ-028 While stall=1, the CPU inputs SHALL be ignored; the CPU re-presents the same request, which must not be re-accepted on return to IDLE unless presented again in IDLE.
REQ-029 dcache_dout SHALL keep its last value except at a read-hit acceptance or a fill.

Reset
REQ-030 Reset SHALL force: state=IDLE, stall=0, mem_req_valid=0, all valid bits=0, dcache_dout=0, mem_req_rw/addr/data/mask=0.
REQ-031 Reset asserted mid-miss or mid-write SHALL abandon the transaction.
REQ-032 A mem_resp_valid arriving after reset deasserts SHALL be ignored per REQ-020.
REQ-033 Tag/data arrays need no reset; only valid bits are reset.

Structure
REQ-034 State encoding and the memory request-type constants (MEM_RD=0, MEM_WR=1) SHALL live in a shared package/header with the other const definitions.
REQ-035 One sub-module, dcache_array, SHALL hold valid/tag/data storage with byte-masked write and one combinational read port.
REQ-036 The FSM and request registers SHALL stay in dcache_responder.

Verification
REQ-037 Scenario cold read miss: re to 0x1000_0004, ready=1, resp after 3 cycles with 0xDEADBEEF -> mem_req addr 0x1000_0004 rw=0, stall high 4 cycles, then dout=0xDEADBEEF, stall=0.
REQ-038 Scenario warm hit: re to 0x1000_0004 again -> no mem_req_valid, stall=0, dout=0xDEADBEEF the next cycle.
REQ-039 Scenario byte write hit: we=4'b0010, din=0x0000AB00 to 0x1000_0004 -> mem_req rw=1 mask=0010; later read hit returns 0xDEADABEF.
REQ-040 Scenario write miss: we=4'hF to 0x2000_0000, ready held low 5 cycles -> stall and request stable 5 cycles, array unchanged, next read of that address misses.
REQ-041 Scenario conflict: read 0x1000_0004 then 0x1000_0104 with LINES=64 -> second read misses and evicts the first; re-read of 0x1000_0004 misses.
REQ-042 Scenario reset in RD_WAIT: assert reset, then send a stray mem_resp_valid -> state IDLE, stall=0, dout=0, stray response ignored, all lines invalid.
